// File: rtl/stack_op_pkg.sv
// Shared PUSH/POP encoding and controller state encoding for the stack operation sequencer.
// Pure definitions: no latency, no backpressure.
package stack_op_pkg;
  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/stack_ptr_unit.sv
// Stack pointer and byte occupancy; under STACK_GUARD_EN also flags PUSH overflow / POP underflow.
// sp/count move one step on the cycle after a granted byte; the guard compare is combinational.
module stack_ptr_unit
  import stack_op_pkg::*;
#(
  parameter int                  CTX_BYTES   = 2,
  parameter int                  SP_WIDTH    = 8,
  parameter logic [SP_WIDTH-1:0] STACK_TOP   = 8'hFF,
  parameter int                  STACK_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_step,
  input  logic                pop_step,
  input  logic                chk_op,
  output logic [SP_WIDTH-1:0] sp,
  output logic                viol
);
  localparam logic [SP_WIDTH-1:0] SP_ONE  = SP_WIDTH'(1);
  localparam logic [SP_WIDTH:0]   CNT_ONE = (SP_WIDTH+1)'(1);
  // One spare bit so count+CTX_BYTES cannot wrap inside the compare.
  localparam logic [SP_WIDTH+1:0] CTX_C   = (SP_WIDTH+2)'(CTX_BYTES);
  localparam logic [SP_WIDTH+1:0] DEPTH_C = (SP_WIDTH+2)'(STACK_DEPTH);

  logic [SP_WIDTH:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= STACK_TOP;
      count <= '0;
    end else if (push_step) begin
      sp    <= sp - SP_ONE;
      count <= count + CNT_ONE;
    end else if (pop_step) begin
      sp    <= sp + SP_ONE;
      count <= count - CNT_ONE;
    end
  end

`ifdef STACK_GUARD_EN
  always_comb begin
    viol = 1'b0;
    if (chk_op == OP_PUSH) viol = ({1'b0, count} + CTX_C) > DEPTH_C;
    else                   viol = {1'b0, count} < CTX_C;
  end
`else
  logic unused_guard;
  assign viol         = 1'b0;
  assign unused_guard = ^{chk_op, count, CTX_C, DEPTH_C};
`endif
endmodule

// File: rtl/stack_op_seq.sv
// Moves CTX_BYTES context bytes to/from a descending byte stack; STACK_GUARD_EN adds ovf/unf guarding.
// Latency CTX_BYTES+1 cycles at full grant; each byte holds bus_req until bus_grant, start while busy is dropped.
module stack_op_seq
  import stack_op_pkg::*;
#(
  parameter int                  CTX_BYTES   = 2,
  parameter int                  SP_WIDTH    = 8,
  parameter logic [SP_WIDTH-1:0] STACK_TOP   = 8'hFF,
  parameter int                  STACK_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [CTX_BYTES*8-1:0] ctx_in,
  output logic [CTX_BYTES*8-1:0] ctx_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   bus_req,
  input  logic                   bus_grant,
  output logic                   mem_wr,
  output logic                   mem_rd,
  output logic [SP_WIDTH-1:0]    mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic [SP_WIDTH-1:0]    sp,
  output logic                   ovf,
  output logic                   unf,
  input  logic                   err_clr
);
  localparam int                  DW     = CTX_BYTES * 8;
  localparam logic [1:0]          K_LAST = 2'(CTX_BYTES - 1);
  localparam logic [SP_WIDTH-1:0] A_ONE  = SP_WIDTH'(1);

  state_t        state;
  logic          op_q;
  logic [DW-1:0] ctx_sh;
  logic [1:0]    k;
  logic          viol, xfer_gnt, guard_hit;

  assign xfer_gnt  = (state == ST_XFER) && bus_grant;
  assign guard_hit = (state == ST_IDLE) && start && viol;
  // The low byte of the shifted context is always the byte currently on the bus.
  assign mem_wdata = ctx_sh[7:0];

  stack_ptr_unit #(
    .CTX_BYTES  (CTX_BYTES),
    .SP_WIDTH   (SP_WIDTH),
    .STACK_TOP  (STACK_TOP),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_step(xfer_gnt && (op_q == OP_PUSH)),
    .pop_step (xfer_gnt && (op_q == OP_POP)),
    .chk_op   (op),
    .sp       (sp),
    .viol     (viol)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_POP;
      ctx_sh   <= '0;
      k        <= '0;
      ctx_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bus_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            ctx_sh <= ctx_in;
            k      <= '0;
            busy   <= 1'b1;
            if (viol) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= ST_XFER;
              bus_req  <= 1'b1;
              mem_wr   <= (op == OP_PUSH);
              mem_rd   <= (op == OP_POP);
              mem_addr <= (op == OP_PUSH) ? sp : sp + A_ONE;
            end
          end
        end
        ST_XFER: begin
          if (bus_grant) begin
            // POP fills from the top byte down so bytes come back in push order.
            if (op_q == OP_POP) ctx_out[8*(CTX_BYTES-1-int'(k)) +: 8] <= mem_rdata;
            else                ctx_sh <= ctx_sh >> 8;
            mem_addr <= (op_q == OP_PUSH) ? mem_addr - A_ONE : mem_addr + A_ONE;
            if (k == K_LAST) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              bus_req <= 1'b0;
              mem_wr  <= 1'b0;
              mem_rd  <= 1'b0;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STACK_GUARD_EN
  // A violation in the same cycle as err_clr leaves its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (err_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (guard_hit) begin
        if (op == OP_PUSH) ovf <= 1'b1;
        else               unf <= 1'b1;
      end
    end
  end
`else
  logic unused_clr;
  assign ovf        = 1'b0;
  assign unf        = 1'b0;
  assign unused_clr = err_clr ^ guard_hit;
`endif
endmodule

// File: tb/tb_stack_op_seq.sv
// Scoreboard bench for stack_op_seq (CTX_BYTES=2, STACK_TOP=FF, STACK_DEPTH=16).
// Guard-dependent expectations follow STACK_GUARD_EN.
module tb_stack_op_seq;
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] dat;
  } xfer_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic        bus_grant = 1'b0, err_clr = 1'b0;
  logic [15:0] ctx_in = 16'h0;
  logic [15:0] ctx_out;
  logic        busy, done, err, bus_req, mem_wr, mem_rd, ovf, unf;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata, sp;

  int checks = 0, errors = 0;

  logic [7:0]  mem [256];
  xfer_t       exp_q[$];
  logic [15:0] m_stack[$];
  logic [7:0]  m_sp = 8'hFF;

  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [16:0] prev_snap = '0;
  xfer_t       mon_e;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_rd && bus_grant) ? mem[mem_addr] : 8'hEE;

  stack_op_seq #(
    .CTX_BYTES(2), .SP_WIDTH(8), .STACK_TOP(8'hFF), .STACK_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ctx_in(ctx_in),
    .ctx_out(ctx_out), .busy(busy), .done(done), .err(err),
    .bus_req(bus_req), .bus_grant(bus_grant), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sp(sp), .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  // Bus monitor: strobe exclusivity, hold stability, scoreboard of granted bytes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus_req) begin
        checks++;
        if ((mem_wr ^ mem_rd) !== 1'b1) begin
          errors++;
          $display("FAIL strobe_excl: wr=%b rd=%b, need exactly one", mem_wr, mem_rd);
        end
        if (prev_req && !prev_gnt) begin
          checks++;
          if ({mem_addr, mem_wdata, mem_wr} !== prev_snap) begin
            errors++;
            $display("FAIL bus_hold: addr/wdata/wr=%h, held value %h", {mem_addr, mem_wdata, mem_wr}, prev_snap);
          end
        end
        if (bus_grant) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_xfer: wr=%b addr=%h, no transfer expected", mem_wr, mem_addr);
          end else begin
            mon_e = exp_q.pop_front();
            if (mem_wr !== mon_e.wr || mem_addr !== mon_e.addr || (mon_e.wr && mem_wdata !== mon_e.dat)) begin
              errors++;
              $display("FAIL bus_xfer: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                       mem_wr, mem_addr, mem_wdata, mon_e.wr, mon_e.addr, mon_e.dat);
            end
          end
          if (mem_wr) mem[mem_addr] = mem_wdata;
        end
      end
      prev_req  = bus_req;
      prev_gnt  = bus_grant;
      prev_snap = {mem_addr, mem_wdata, mem_wr};
    end
  end

  function automatic void exp_push(input logic [15:0] v);
    exp_q.push_back('{1'b1, m_sp, v[7:0]});
    exp_q.push_back('{1'b1, 8'(m_sp - 8'd1), v[15:8]});
    m_sp = 8'(m_sp - 8'd2);
    m_stack.push_back(v);
  endfunction

  function automatic void exp_pop(output logic [15:0] v);
    logic [7:0] a0, a1;
    a0 = 8'(m_sp + 8'd1);
    a1 = 8'(m_sp + 8'd2);
    exp_q.push_back('{1'b0, a0, 8'h00});
    exp_q.push_back('{1'b0, a1, 8'h00});
    m_sp = a1;
    if (m_stack.size() != 0) v = m_stack.pop_back();
    else                     v = {mem[a0], mem[a1]};
  endfunction

  // Drives one start and a grant pattern (grant on the (gdelay+1)-th held cycle), waits for done.
  task automatic run_op(input logic is_push, input logic [15:0] val, input int gdelay,
                        output int lat, output logic err_seen, output logic [15:0] ctx_seen);
    int held;
    bit fin;
    @(posedge clk); #1;
    start = 1'b1; op = is_push; ctx_in = val;
    bus_grant = (gdelay == 0);
    held = 0; lat = 0; fin = 0; err_seen = 1'b0; ctx_seen = 16'h0;
    for (int n = 1; n <= 60 && !fin; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin start = 1'b0; ctx_in = 16'h0; end
      if (done) begin
        lat = n; err_seen = err; ctx_seen = ctx_out; fin = 1;
      end else if (gdelay != 0 && bus_req) begin
        bus_grant = (held == gdelay);
        held = bus_grant ? 0 : held + 1;
      end
    end
    bus_grant = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL op_timeout: no done within 60 cycles (op=%b)", is_push);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, bus_req, mem_wr, mem_rd, ovf, unf} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/err/req/wr/rd/ovf/unf=%b, required 0", {busy, done, err, bus_req, mem_wr, mem_rd, ovf, unf});
    end
    checks++;
    if (sp !== 8'hFF) begin errors++; $display("FAIL reset_sp: %h vs FF", sp); end
    checks++;
    if (ctx_out !== 16'h0) begin errors++; $display("FAIL reset_ctx: %h vs 0000", ctx_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_push_pop();
    int lat; logic e; logic [15:0] c, v;
    exp_push(16'hA55A);
    run_op(1'b1, 16'hA55A, 0, lat, e, c);
    checks++;
    if (lat != 3 || e !== 1'b0) begin errors++; $display("FAIL push_lat: lat=%0d err=%b, required 3/0", lat, e); end
    checks++;
    if (sp !== 8'hFD) begin errors++; $display("FAIL push_sp: %h vs FD", sp); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b busy=%b, required 0/0", done, busy); end
    exp_pop(v);
    run_op(1'b0, 16'h0, 0, lat, e, c);
    checks++;
    if (c !== 16'hA55A || v !== 16'hA55A) begin errors++; $display("FAIL pop_ctx: %h vs A55A", c); end
    checks++;
    if (lat != 3 || e !== 1'b0 || sp !== 8'hFF) begin errors++; $display("FAIL pop_state: lat=%0d err=%b sp=%h, required 3/0/FF", lat, e, sp); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL push_pop_drain: %0d xfers outstanding, 0 required", exp_q.size()); end
  endtask

  task automatic test_delayed_grant();
    int lat; logic e; logic [15:0] c, v;
    exp_push(16'h1234);
    run_op(1'b1, 16'h1234, 2, lat, e, c);
    checks++;
    if (lat != 7 || sp !== 8'hFD) begin errors++; $display("FAIL slow_push: lat=%0d sp=%h, required 7/FD", lat, sp); end
    exp_pop(v);
    run_op(1'b0, 16'h0, 2, lat, e, c);
    checks++;
    if (lat != 7 || c !== v) begin errors++; $display("FAIL slow_pop: lat=%0d ctx=%h, required 7/%h", lat, c, v); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL slow_drain: %0d xfers outstanding, 0 required", exp_q.size()); end
  endtask

  task automatic test_fill();
    int lat, npop; logic e; logic [15:0] c, v;
    for (int i = 0; i < 8; i++) begin
      v = {8'(8'h10 + i), 8'(8'hA0 + 3*i)};
      exp_push(v);
      run_op(1'b1, v, (i % 2), lat, e, c);
    end
    checks++;
    if (sp !== 8'hEF) begin errors++; $display("FAIL fill_sp: %h vs EF", sp); end
`ifdef STACK_GUARD_EN
    run_op(1'b1, 16'hC0DE, 0, lat, e, c);
    checks++;
    if (lat != 1 || e !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_guard: lat=%0d err=%b ovf=%b, required 1/1/1", lat, e, ovf); end
    checks++;
    if (sp !== 8'hEF) begin errors++; $display("FAIL ovf_sp: %h vs EF", sp); end
    npop = 8;
`else
    exp_push(16'hC0DE);
    run_op(1'b1, 16'hC0DE, 0, lat, e, c);
    checks++;
    if (lat != 3 || e !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL over_push: lat=%0d err=%b ovf=%b, required 3/0/0", lat, e, ovf); end
    checks++;
    if (sp !== 8'hED) begin errors++; $display("FAIL over_sp: %h vs ED", sp); end
    npop = 9;
`endif
    for (int i = 0; i < npop; i++) begin
      exp_pop(v);
      run_op(1'b0, 16'h0, 0, lat, e, c);
      checks++;
      if (c !== v) begin errors++; $display("FAIL lifo_%0d: %h vs %h", i, c, v); end
    end
    checks++;
    if (sp !== 8'hFF || exp_q.size() != 0) begin errors++; $display("FAIL unwind: sp=%h pending=%0d, required FF/0", sp, exp_q.size()); end
  endtask

  task automatic test_empty_pop();
    int lat; logic e; logic [15:0] c, v;
`ifdef STACK_GUARD_EN
    run_op(1'b0, 16'h0, 0, lat, e, c);
    checks++;
    if (lat != 1 || e !== 1'b1 || unf !== 1'b1) begin errors++; $display("FAIL unf_guard: lat=%0d err=%b unf=%b, required 1/1/1", lat, e, unf); end
    checks++;
    if (sp !== 8'hFF) begin errors++; $display("FAIL unf_sp: %h vs FF", sp); end
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    checks++;
    if (unf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL err_clr: ovf=%b unf=%b, required 0/0", ovf, unf); end
    start = 1'b1; op = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1; start = 1'b0; err_clr = 1'b0;
    checks++;
    if (unf !== 1'b1 || done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL set_wins: unf=%b done=%b err=%b, required 1/1/1", unf, done, err); end
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
`else
    exp_pop(v);
    run_op(1'b0, 16'h0, 0, lat, e, c);
    checks++;
    if (c !== v || e !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL wrap_pop: ctx=%h err=%b unf=%b, required %h/0/0", c, e, unf, v); end
    checks++;
    if (sp !== 8'h01) begin errors++; $display("FAIL wrap_sp: %h vs 01", sp); end
    exp_push(16'hBEEF);
    run_op(1'b1, 16'hBEEF, 0, lat, e, c);
    checks++;
    if (sp !== 8'hFF) begin errors++; $display("FAIL wrap_back: %h vs FF", sp); end
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL empty_drain: %0d xfers outstanding, 0 required", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    exp_push(16'h7788);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; ctx_in = 16'h7788; bus_grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sp !== 8'hFE || bus_req !== 1'b1) begin errors++; $display("FAIL abort_pre: sp=%h req=%b, required FE/1", sp, bus_req); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0 || mem_wr !== 1'b0 || sp !== 8'hFF) begin
      errors++;
      $display("FAIL abort_now: req=%b busy=%b wr=%b sp=%h, required 0/0/0/FF", bus_req, busy, mem_wr, sp);
    end
    exp_q.delete();
    m_stack.delete();
    m_sp = 8'hFF;
    bus_grant = 1'b0;
    seen_done = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (n == 2) rst_n = 1'b1;
      if (done) seen_done = 1;
    end
    checks++;
    if (seen_done || busy !== 1'b0) begin errors++; $display("FAIL abort_done: done seen=%0d busy=%b, required 0/0", seen_done, busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    test_reset();
    test_push_pop();
    test_delayed_grant();
    test_fill();
    test_empty_pop();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
